// File: rtl/flit_inject_ni.sv
// Injection NI: takes terminal flits, allocates a VC per packet, tracks per-VC credits, drives one router input channel.
// Latency: one cycle from accepted flit to channel_out; credit returns affect send decisions one cycle later.
// Backpressure: inj_ready drops while no VC has credit (head) or the packet's VC is out of credit (body/tail).
module flit_inject_ni #(
   parameter  int num_vcs      = 4,
   parameter  int buffer_size  = 8,
   parameter  int data_width   = 64,
   localparam int vc_idx_width = $clog2(num_vcs),
   localparam int cnt_width    = $clog2(buffer_size + 1),
   localparam int chan_width   = 3 + vc_idx_width + data_width
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inj_valid,
   input  logic                    inj_head,
   input  logic                    inj_tail,
   input  logic [data_width-1:0]   inj_data,
   output logic                    inj_ready,
   output logic [0:chan_width-1]   channel_out,
   input  logic [0:vc_idx_width]   flow_ctrl_in,
   output logic                    error
);

   typedef logic [vc_idx_width-1:0] vc_t;
   typedef logic [cnt_width-1:0]    cnt_t;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   localparam cnt_t                    cnt_full = cnt_t'(buffer_size);
   localparam logic [vc_idx_width:0]   vc_limit = (vc_idx_width + 1)'(num_vcs);

   // Registered state
   logic [0:0]            state_q,  state_d;
   vc_t                   cur_vc_q, cur_vc_d;
   vc_t                   rr_ptr_q, rr_ptr_d;
   cnt_t                  credit_q [num_vcs];
   cnt_t                  credit_d [num_vcs];
   logic [chan_width-1:0] chan_q,   chan_d;
   logic                  error_q,  error_d;

   // Per-cycle decisions
   logic                  cand_found;
   vc_t                   cand_vc;
   logic                  send;
   vc_t                   send_vc;
   logic                  proto_err;
   logic                  ovf_err;
   logic                  fc_vld;
   vc_t                   fc_idx;
   logic [vc_idx_width:0] fc_idx_ext;
   logic                  fc_bad;

   // Modular VC increment, safe for non-power-of-two VC counts
   function automatic vc_t vc_add(input vc_t base, input int off);
      return vc_t'((int'(base) + off) % num_vcs);
   endfunction

   // Round-robin search for the first VC with credit, starting at rr_ptr
   always_comb begin
      cand_found = 1'b0;
      cand_vc    = rr_ptr_q;
      for (int i = 0; i < num_vcs; i++) begin
         if (!cand_found && (credit_q[vc_add(rr_ptr_q, i)] != '0)) begin
            cand_found = 1'b1;
            cand_vc    = vc_add(rr_ptr_q, i);
         end
      end
   end

   // Handshake and packet FSM; protocol violations are swallowed with ready=1 so the terminal never wedges
   always_comb begin
      inj_ready = 1'b0;
      send      = 1'b0;
      send_vc   = cur_vc_q;
      proto_err = 1'b0;
      state_d   = state_q;
      cur_vc_d  = cur_vc_q;
      rr_ptr_d  = rr_ptr_q;
      if (inj_valid) begin
         if (state_q == ST_IDLE) begin
            if (inj_head) begin
               if (cand_found) begin
                  inj_ready = 1'b1;
                  send      = 1'b1;
                  send_vc   = cand_vc;
                  rr_ptr_d  = vc_add(cand_vc, 1);
                  if (!inj_tail) begin
                     state_d  = ST_ACTIVE;
                     cur_vc_d = cand_vc;
                  end
               end
            end else begin
               // body/tail with no open packet: drop it
               inj_ready = 1'b1;
               proto_err = 1'b1;
            end
         end else begin
            if (!inj_head) begin
               inj_ready = (credit_q[cur_vc_q] != '0);
               send      = inj_ready;
               if (inj_ready && inj_tail) begin
                  state_d = ST_IDLE;
               end
            end else begin
               // head inside an open packet: drop it, keep the packet open
               inj_ready = 1'b1;
               proto_err = 1'b1;
            end
         end
      end
   end

   // Outgoing flit image; an idle cycle drives all zeros, not just valid=0
   always_comb begin
      chan_d = '0;
      if (send) begin
         chan_d = {1'b1, inj_head, inj_tail, send_vc, inj_data};
      end
   end

   // Decode the returned credit and flag VC indices outside the implemented range
   always_comb begin
      fc_vld     = flow_ctrl_in[0];
      fc_idx     = flow_ctrl_in[1:vc_idx_width];
      fc_idx_ext = {1'b0, fc_idx};
      fc_bad     = fc_vld && (fc_idx_ext >= vc_limit);
   end

   // Per-VC credit counters: minus a send, plus a return; a return to a full counter is an overflow
   always_comb begin
      ovf_err = 1'b0;
      for (int v = 0; v < num_vcs; v++) begin
         logic sent_v;
         logic ret_v;
         sent_v = send && (send_vc == vc_t'(v));
         ret_v  = fc_vld && !fc_bad && (fc_idx == vc_t'(v));
         credit_d[vc_t'(v)] = credit_q[vc_t'(v)];
         if (sent_v && !ret_v) begin
            credit_d[vc_t'(v)] = credit_q[vc_t'(v)] - cnt_t'(1);
         end else if (ret_v && !sent_v) begin
            if (credit_q[vc_t'(v)] == cnt_full) begin
               ovf_err = 1'b1;
            end else begin
               credit_d[vc_t'(v)] = credit_q[vc_t'(v)] + cnt_t'(1);
            end
         end
      end
   end

   // Sticky error: any protocol, overflow or bad-index event latches until reset
   always_comb begin
      error_d = error_q | proto_err | ovf_err | fc_bad;
   end

   // State registers; reset abandons any open packet and refills all credits
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cur_vc_q <= '0;
         rr_ptr_q <= '0;
         chan_q   <= '0;
         error_q  <= 1'b0;
         for (int v = 0; v < num_vcs; v++) begin
            credit_q[vc_t'(v)] <= cnt_full;
         end
      end else begin
         state_q  <= state_d;
         cur_vc_q <= cur_vc_d;
         rr_ptr_q <= rr_ptr_d;
         chan_q   <= chan_d;
         error_q  <= error_d;
         for (int v = 0; v < num_vcs; v++) begin
            credit_q[vc_t'(v)] <= credit_d[vc_t'(v)];
         end
      end
   end

   assign channel_out = chan_q;
   assign error       = error_q;

endmodule

// File: tb/tb_flit_inject_ni.sv
// Directed bench for flit_inject_ni: VC allocation, credit tracking, backpressure, errors and reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
// Expected values are hand-derived from the channel format {valid, head, tail, vc, data}.
module tb_flit_inject_ni;

   localparam int NV = 4;
   localparam int DW = 64;
   localparam int CW = 3 + 2 + DW;

   logic           clk = 1'b0;
   logic           reset;
   logic           inj_valid;
   logic           inj_head;
   logic           inj_tail;
   logic [DW-1:0]  inj_data;
   logic           inj_ready;
   logic [0:CW-1]  channel_out;
   logic [0:2]     flow_ctrl_in;
   logic           error;

   int n_checks = 0;
   int n_fail   = 0;

   flit_inject_ni #(.num_vcs(NV), .buffer_size(8), .data_width(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .inj_valid    (inj_valid),
      .inj_head     (inj_head),
      .inj_tail     (inj_tail),
      .inj_data     (inj_data),
      .inj_ready    (inj_ready),
      .channel_out  (channel_out),
      .flow_ctrl_in (flow_ctrl_in),
      .error        (error)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [CW-1:0] flit(input logic h, input logic t, input logic [1:0] vc,
                                          input logic [DW-1:0] d);
      return {1'b1, h, t, vc, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inj_valid = 1'b0;
      inj_head  = 1'b0;
      inj_tail  = 1'b0;
      inj_data  = '0;
   endtask

   task automatic drive(input logic h, input logic t, input logic [DW-1:0] d);
      inj_valid = 1'b1;
      inj_head  = h;
      inj_tail  = t;
      inj_data  = d;
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      flow_ctrl_in = '0;
      idle();
      step();
      step();
      reset = 1'b0;
   endtask

   // Present a flit that must be accepted and appear next cycle on vc
   task automatic send_flit(input string tag, input logic h, input logic t,
                            input logic [DW-1:0] d, input logic [1:0] vc);
      drive(h, t, d);
      check({tag, "_rdy"}, inj_ready, 1'b1);
      step();
      check(tag, channel_out, flit(h, t, vc, d));
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_chan", channel_out, '0);
      check("rst_err", error, 1'b0);

      // Single-flit packet lands on VC0 for exactly one cycle
      send_flit("single", 1'b1, 1'b1, 64'hA5, 2'd0);
      idle();
      step();
      check("single_gone", channel_out, '0);
      // rr_ptr advanced: next head picks VC1
      send_flit("rr_next", 1'b1, 1'b1, 64'h11, 2'd1);
      idle();

      // 3-flit packet on VC0, then back-to-back single on VC1
      do_reset();
      send_flit("p3_h", 1'b1, 1'b0, 64'h100, 2'd0);
      send_flit("p3_b", 1'b0, 1'b0, 64'h101, 2'd0);
      send_flit("p3_t", 1'b0, 1'b1, 64'h102, 2'd0);
      send_flit("p1_b2b", 1'b1, 1'b1, 64'h200, 2'd1);
      idle();

      // 10-flit packet: 8 flits drain VC0, then stall until a credit returns
      do_reset();
      for (int i = 0; i < 8; i++) begin
         send_flit("p10", (i == 0), 1'b0, 64'h300 + 64'(i), 2'd0);
      end
      drive(1'b0, 1'b0, 64'h308);
      check("p10_stall_rdy", inj_ready, 1'b0);
      step();
      check("p10_stall_chan", channel_out, '0);
      flow_ctrl_in = {1'b1, 2'd0};
      #1;
      check("p10_fc_same_cycle", inj_ready, 1'b0);
      step();
      flow_ctrl_in = '0;
      #1;
      check("p10_fc_next_rdy", inj_ready, 1'b1);
      step();
      check("p10_flit9", channel_out, flit(1'b0, 1'b0, 2'd0, 64'h308));
      check("p10_err", error, 1'b0);
      idle();

      // VC2 brought to 3 credits; simultaneous send+return on VC2 leaves it at 3
      do_reset();
      send_flit("s_vc0", 1'b1, 1'b1, 64'h400, 2'd0);
      send_flit("s_vc1", 1'b1, 1'b1, 64'h401, 2'd1);
      for (int i = 0; i < 5; i++) begin
         send_flit("p6_vc2", (i == 0), 1'b0, 64'h410 + 64'(i), 2'd2);
      end
      flow_ctrl_in = {1'b1, 2'd2};
      send_flit("p6_tail_fc", 1'b0, 1'b1, 64'h415, 2'd2);
      flow_ctrl_in = '0;
      send_flit("s_vc3", 1'b1, 1'b1, 64'h420, 2'd3);
      send_flit("s_vc0b", 1'b1, 1'b1, 64'h421, 2'd0);
      send_flit("s_vc1b", 1'b1, 1'b1, 64'h422, 2'd1);
      for (int i = 0; i < 3; i++) begin
         send_flit("vc2_three", (i == 0), 1'b0, 64'h430 + 64'(i), 2'd2);
      end
      drive(1'b0, 1'b1, 64'h433);
      check("vc2_exhaust_rdy", inj_ready, 1'b0);
      check("vc2_no_err", error, 1'b0);
      idle();

      // All VCs drained: a head waits with no error
      do_reset();
      for (int p = 0; p < NV; p++) begin
         for (int f = 0; f < 8; f++) begin
            send_flit("drain", (f == 0), (f == 7), 64'h500 + 64'(p * 8 + f), 2'(p));
         end
      end
      drive(1'b1, 1'b1, 64'h5FF);
      for (int c = 0; c < 4; c++) begin
         check("all0_rdy", inj_ready, 1'b0);
         step();
         check("all0_chan", channel_out, '0);
      end
      check("all0_err", error, 1'b0);
      idle();

      // Credit overflow on a full VC3 sets a sticky error
      do_reset();
      flow_ctrl_in = {1'b1, 2'd3};
      step();
      flow_ctrl_in = '0;
      check("ovf_err", error, 1'b1);
      check("ovf_chan", channel_out, '0);
      step();
      step();
      check("ovf_sticky", error, 1'b1);

      // Body flit with no open packet: accepted, dropped, error set
      do_reset();
      check("body_idle_err0", error, 1'b0);
      drive(1'b0, 1'b0, 64'h600);
      check("body_idle_rdy", inj_ready, 1'b1);
      step();
      check("body_idle_chan", channel_out, '0);
      check("body_idle_err", error, 1'b1);
      idle();

      // Head inside an open packet: dropped, packet stays on its VC
      do_reset();
      send_flit("hh_h", 1'b1, 1'b0, 64'h700, 2'd0);
      drive(1'b1, 1'b0, 64'h701);
      check("hh_rdy", inj_ready, 1'b1);
      step();
      check("hh_chan", channel_out, '0);
      check("hh_err", error, 1'b1);
      send_flit("hh_t", 1'b0, 1'b1, 64'h702, 2'd0);
      idle();

      // Reset mid-packet (VC1 at 4 credits, error set) clears everything
      do_reset();
      send_flit("mr_vc0", 1'b1, 1'b1, 64'h800, 2'd0);
      for (int i = 0; i < 4; i++) begin
         send_flit("mr_vc1", (i == 0), 1'b0, 64'h810 + 64'(i), 2'd1);
      end
      drive(1'b1, 1'b0, 64'h820);
      step();
      check("mr_err_pre", error, 1'b1);
      reset = 1'b1;
      drive(1'b0, 1'b0, 64'h821);
      step();
      reset = 1'b0;
      check("mr_chan", channel_out, '0);
      check("mr_err", error, 1'b0);
      send_flit("mr_new_vc0", 1'b1, 1'b1, 64'h830, 2'd0);
      for (int i = 0; i < 8; i++) begin
         send_flit("mr_vc1_full", (i == 0), 1'b0, 64'h840 + 64'(i), 2'd1);
      end
      drive(1'b0, 1'b1, 64'h848);
      check("mr_vc1_stall", inj_ready, 1'b0);
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flit_inject_ni.md
# flit_inject_ni

Injection network interface that sits directly upstream of a router input port and drives one router input channel. Accepts packet flits from a terminal over a valid/ready interface, allocates a virtual channel per packet, tracks per-VC downstream buffer credits, and emits registered flits on a channel whose credits come back on a matching flow-control input. Wormhole switching: a packet is locked to its VC from head to tail.

## Interface
- num_vcs, 4: VCs per router port; vc_idx_width = clog2(num_vcs).
- buffer_size, 8: flit buffer depth per VC in the router; initial credit count.
- data_width, 64: flit payload width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- inj_valid  in  1  terminal flit valid.
- inj_head  in  1  flit is packet head.
- inj_tail  in  1  flit is packet tail; head and tail together means a single-flit packet.
- inj_data  in  data_width  flit payload.
- inj_ready  out  1  flit accepted this cycle when inj_valid && inj_ready.
- channel_out  out  [0:3+vc_idx_width+data_width-1]  [0]=valid, [1]=head, [2]=tail, [3:3+vc_idx_width-1]=VC index, remainder=payload.
- flow_ctrl_in  in  [0:vc_idx_width]  [0]=credit valid, [1:vc_idx_width]=VC index of returned credit.
- error  out  1  sticky protocol/credit error flag.

## Operation
- State per VC: credit counter, width clog2(buffer_size+1), reset to buffer_size.
- FSM states: IDLE (no packet open), ACTIVE (packet open on cur_vc).
- IDLE, inj_valid && inj_head: candidate VCs are those with credit > 0; round-robin select starting at rr_ptr. If a candidate exists: inj_ready=1, flit sent on selected VC, rr_ptr <= selected+1 (mod num_vcs); if !inj_tail, go ACTIVE with cur_vc=selected. If no candidate: inj_ready=0, hold.
- IDLE, inj_valid && !inj_head: protocol error; inj_ready=1, flit dropped, error set.
- ACTIVE, inj_valid && !inj_head: inj_ready = (credit[cur_vc] > 0); on accept send on cur_vc; inj_tail returns to IDLE.
- ACTIVE, inj_valid && inj_head: protocol error; inj_ready=1, flit dropped, error set, state unchanged.
- Credit update per VC: cnt_next = cnt - sent + returned. Send and return on the same VC in the same cycle leave cnt unchanged.
- Credit return to a VC with cnt == buffer_size and no send that cycle: overflow; cnt holds at buffer_size, error set.
- Flow-control VC index >= num_vcs with credit valid: ignored, error set.
- error, once set, stays 1 until reset.
- Reset, including mid-packet: state IDLE, cur_vc=0, rr_ptr=0, all credits = buffer_size, channel_out all zeros, error=0. The partial packet is abandoned; the terminal restarts with a head flit.

## Timing
- inj_ready is combinational from registered state and credit counters plus inj_valid/inj_head. It does not depend on same-cycle flow_ctrl_in.
- A credit returned in cycle t is visible to send decisions in cycle t+1.
- channel_out is registered. A flit accepted in cycle t appears in cycle t+1 for exactly one cycle. With no accept, channel_out is all zeros, not merely valid=0.
- Throughput is 1 flit/cycle while the target VC has credit. Back-to-back packets need no idle cycle between a tail and the next head.
- error asserts in the cycle after the offending event.

## Test plan
- Reset, then single-flit packet (head=1, tail=1, data=0xA5) in cycle 0 -> cycle 1 channel_out valid=1, head=1, tail=1, VC=0, data=0xA5; VC0 credit=7; rr_ptr=1; FSM IDLE.
- 3-flit packet, then a second 1-flit packet back-to-back, no credit returns -> first packet's 3 flits all on VC0 in cycles 1-3; second packet on VC1 in cycle 4; VC0 credit=5, VC1 credit=7.
- 10-flit packet, no credit returns -> flits 1-8 on VC0, then inj_ready=0. Credit return for VC0 in cycle t -> inj_ready=1 in t+1 and flit 9 on channel_out in t+2.
- VC2 at credit 3: send on VC2 and return a VC2 credit in the same cycle -> VC2 credit stays 3. All four VCs at 0 with a head presented -> inj_ready=0 indefinitely and no error.
- Credit return on VC3 while at 8 -> error=1 next cycle, stays 1. A body flit in IDLE after reset -> inj_ready=1, nothing on channel_out, error=1.
- Reset asserted mid-packet (ACTIVE, VC1 credit=4) -> next cycle channel_out=0, error=0, all credits 8, a new head goes to VC0.
